// File: rtl/cd_ctrl.sv
// cd_ctrl: four-channel clock divider with glitch-free runtime ratio updates.
// Optional macro CD_CTRL_TICK_EN adds per-channel rising-edge tick pulses.
module cd_ctrl #(
  parameter int CNT_W        = 20,
  parameter int DIV_VGA_RST  = 1,
  parameter int DIV_UART_RST = 217,
  parameter int DIV_LM_RST   = 25000,
  parameter int DIV_DB_RST   = 250000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_div,
  output logic [3:0]       busy,
`ifdef CD_CTRL_TICK_EN
  output logic [3:0]       tick,
`endif
  output logic             clk_VGA,
  output logic             clk_UART,
  output logic             clk_LM,
  output logic             clk_DB
);

  typedef logic [CNT_W-1:0] cnt_t;

  // S_LOAD: update accepted while OFF, applied on the following edge
  typedef enum logic [1:0] {
    S_OFF,
    S_RUN,
    S_PEND,
    S_LOAD
  } st_t;

  st_t        r_st  [4];
  st_t        w_st  [4];
  cnt_t       r_cnt [4];
  cnt_t       w_cnt [4];
  cnt_t       r_cur [4];
  cnt_t       w_cur [4];
  cnt_t       r_nxt [4];
  cnt_t       w_nxt [4];
  logic [3:0] r_clk;
  logic [3:0] w_clk;
  logic [3:0] w_acc;
  logic [3:0] w_end;

  function automatic cnt_t f_rst(input int ch);
    case (ch)
      0:       return cnt_t'(DIV_VGA_RST);
      1:       return cnt_t'(DIV_UART_RST);
      2:       return cnt_t'(DIV_LM_RST);
      default: return cnt_t'(DIV_DB_RST);
    endcase
  endfunction

  always_comb begin
    busy = '0;
    for (int i = 0; i < 4; i++) begin
      busy[i] = (r_st[i] == S_PEND) || (r_st[i] == S_LOAD);
    end
  end

  assign cfg_ready = ~busy[cfg_sel];

  always_comb begin
    w_acc = '0;
    w_end = '0;
    w_clk = r_clk;
    for (int i = 0; i < 4; i++) begin
      w_st[i]  = r_st[i];
      w_cnt[i] = r_cnt[i];
      w_cur[i] = r_cur[i];
      w_nxt[i] = r_nxt[i];
      w_acc[i] = cfg_valid && cfg_ready && (cfg_sel == 2'(i));
      w_end[i] = (r_cnt[i] == r_cur[i] - cnt_t'(1));
      unique case (r_st[i])
        S_OFF: begin
          if (w_acc[i]) begin
            w_nxt[i] = cfg_div;
            w_st[i]  = S_LOAD;
          end
        end
        S_LOAD: begin
          w_cur[i] = r_nxt[i];
          w_cnt[i] = '0;
          w_clk[i] = 1'b0;
          w_st[i]  = (r_nxt[i] == '0) ? S_OFF : S_RUN;
        end
        S_RUN, S_PEND: begin
          if (w_end[i]) begin
            w_cnt[i] = '0;
            w_clk[i] = ~r_clk[i];
            // pending ratio lands only on the high-to-low boundary
            if (r_st[i] == S_PEND && r_clk[i]) begin
              w_clk[i] = 1'b0;
              w_cur[i] = r_nxt[i];
              w_st[i]  = (r_nxt[i] == '0) ? S_OFF : S_RUN;
            end
          end else begin
            w_cnt[i] = r_cnt[i] + cnt_t'(1);
          end
          if (r_st[i] == S_RUN && w_acc[i]) begin
            w_nxt[i] = cfg_div;
            w_st[i]  = S_PEND;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk <= '0;
      for (int i = 0; i < 4; i++) begin
        r_st[i]  <= (f_rst(i) == '0) ? S_OFF : S_RUN;
        r_cnt[i] <= '0;
        r_cur[i] <= f_rst(i);
        r_nxt[i] <= '0;
      end
    end else begin
      r_clk <= w_clk;
      for (int i = 0; i < 4; i++) begin
        r_st[i]  <= w_st[i];
        r_cnt[i] <= w_cnt[i];
        r_cur[i] <= w_cur[i];
        r_nxt[i] <= w_nxt[i];
      end
    end
  end

`ifdef CD_CTRL_TICK_EN
  logic [3:0] r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
    end else begin
      r_tick <= w_clk & ~r_clk;
    end
  end

  assign tick = r_tick;
`endif

  assign clk_VGA  = r_clk[0];
  assign clk_UART = r_clk[1];
  assign clk_LM   = r_clk[2];
  assign clk_DB   = r_clk[3];

endmodule

// File: tb/tb_cd_ctrl.sv
// tb_cd_ctrl: directed stimulus with a cycle-stamped expectation queue
// drained by an independent monitor on the falling clock edge.
module tb_cd_ctrl;
  localparam int CNT_W = 20;
  localparam int R     = 3;
  localparam int R2    = R + 1370;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cfg_valid = 1'b0;
  logic [1:0]       cfg_sel = 2'd0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic [3:0]       busy;
  logic             clk_VGA, clk_UART, clk_LM, clk_DB;
`ifdef CD_CTRL_TICK_EN
  logic [3:0]       tick;
`endif

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    int   cyc;
    int   sig;
    logic val;
  } chk_t;

  chk_t q[$];

  cd_ctrl #(
    .CNT_W(CNT_W),
    .DIV_LM_RST(50),
    .DIV_DB_RST(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel),
    .cfg_div(cfg_div),
    .busy(busy),
`ifdef CD_CTRL_TICK_EN
    .tick(tick),
`endif
    .clk_VGA(clk_VGA),
    .clk_UART(clk_UART),
    .clk_LM(clk_LM),
    .clk_DB(clk_DB)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sname(input int s);
    case (s)
      0: return "clk_VGA";
      1: return "clk_UART";
      2: return "clk_LM";
      3: return "clk_DB";
      8: return "cfg_ready";
      default:
        if (s < 8) return $sformatf("busy[%0d]", s - 4);
        else return $sformatf("tick[%0d]", s - 9);
    endcase
  endfunction

  function automatic logic get(input int s);
    case (s)
      0: return clk_VGA;
      1: return clk_UART;
      2: return clk_LM;
      3: return clk_DB;
      4, 5, 6, 7: return busy[s-4];
      8: return cfg_ready;
`ifdef CD_CTRL_TICK_EN
      9, 10, 11, 12: return tick[s-9];
`endif
      default: return 1'bx;
    endcase
  endfunction

  function automatic void ex(input int c, input int s, input logic v);
    chk_t e;
    int   k;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    k = q.size();
    while (k > 0 && q[k-1].cyc > c) k--;
    q.insert(k, e);
  endfunction

  function automatic void ex_idle(input int c);
    for (int s = 0; s < 8; s++) ex(c, s, 1'b0);
    ex(c, 8, 1'b1);
`ifdef CD_CTRL_TICK_EN
    for (int s = 9; s < 13; s++) ex(c, s, 1'b0);
`endif
  endfunction

  task automatic at(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [1:0] s,
                     input logic [CNT_W-1:0] d);
    cfg_valid = v;
    cfg_sel   = s;
    cfg_div   = d;
  endtask

  initial begin
    chk_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        if (get(e.sig) !== e.val) begin
          n_bad++;
          $display("FAIL %s cyc=%0d actual=%b required=%b",
                   sname(e.sig), e.cyc, get(e.sig), e.val);
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    ex_idle(1);

    // defaults after release
    ex(R+1, 0, 1); ex(R+2, 0, 0); ex(R+3, 0, 1);
    ex(R+1, 4, 0); ex(R+1, 5, 0); ex(R+1, 8, 1);
    ex(R+216, 1, 0); ex(R+217, 1, 1); ex(R+433, 1, 1);
    ex(R+434, 1, 0); ex(R+650, 1, 0); ex(R+651, 1, 1);
    ex(R+5, 3, 0); ex(R+6, 3, 1);
`ifdef CD_CTRL_TICK_EN
    ex(R+1, 9, 1); ex(R+2, 9, 0); ex(R+3, 9, 1);
    ex(R+216, 10, 0); ex(R+217, 10, 1); ex(R+218, 10, 0);
    ex(R+651, 10, 1);
`endif
    at(R);
    rst_n = 1'b1;

    // VGA ratio 1 -> 2
    ex(R+653, 4, 1); ex(R+653, 8, 0); ex(R+654, 4, 0); ex(R+654, 8, 1);
    ex(R+654, 0, 0); ex(R+655, 0, 0); ex(R+656, 0, 1);
    ex(R+657, 0, 1); ex(R+658, 0, 0); ex(R+659, 0, 0); ex(R+660, 0, 1);
`ifdef CD_CTRL_TICK_EN
    ex(R+656, 9, 1); ex(R+657, 9, 0);
`endif
    at(R+652); drv(1, 0, 2);
    at(R+653); drv(0, 0, 0);

    // UART pending with a held second write; LM write in the same window
    ex(R+869, 5, 1); ex(R+871, 8, 0);
    ex(R+870, 6, 1); ex(R+899, 6, 1); ex(R+900, 6, 0);
    ex(R+899, 2, 1); ex(R+900, 2, 0); ex(R+903, 2, 0);
    ex(R+904, 2, 1); ex(R+907, 2, 1); ex(R+908, 2, 0);
    ex(R+1301, 8, 0); ex(R+1302, 8, 1); ex(R+1303, 8, 0);
    ex(R+1301, 5, 1); ex(R+1302, 5, 0); ex(R+1303, 5, 1);
    ex(R+1311, 5, 1); ex(R+1312, 5, 0);
    ex(R+1301, 1, 1); ex(R+1302, 1, 0); ex(R+1306, 1, 0);
    ex(R+1307, 1, 1); ex(R+1311, 1, 1); ex(R+1312, 1, 0);
    ex(R+1314, 1, 0); ex(R+1315, 1, 1); ex(R+1317, 1, 1);
    ex(R+1318, 1, 0);
    at(R+868); drv(1, 1, 5);
    at(R+869); drv(1, 2, 4);
    at(R+870); drv(1, 1, 3);
    at(R+1303); drv(0, 1, 0);

    // DB stop, then restart from OFF
    ex(R+1321, 7, 1); ex(R+1331, 7, 1); ex(R+1332, 7, 0);
    ex(R+1331, 3, 1); ex(R+1332, 3, 0); ex(R+1340, 3, 0);
    ex(R+1341, 7, 1); ex(R+1342, 7, 0);
    ex(R+1341, 3, 0); ex(R+1344, 3, 0); ex(R+1345, 3, 1);
    ex(R+1347, 3, 1); ex(R+1348, 3, 0); ex(R+1350, 3, 0);
    ex(R+1351, 3, 1);
`ifdef CD_CTRL_TICK_EN
    ex(R+1340, 12, 0); ex(R+1345, 12, 1); ex(R+1346, 12, 0);
    ex(R+1351, 12, 1);
`endif
    at(R+1320); drv(1, 3, 0);
    at(R+1321); drv(0, 3, 0);
    at(R+1340); drv(1, 3, 3);
    at(R+1341); drv(0, 3, 0);

    // reset mid-period drops the pending UART update
    ex(R+1361, 5, 1); ex(R+1363, 5, 1); ex(R+1363, 1, 1);
    ex_idle(R+1364); ex_idle(R+1369);
    ex(R2+1, 0, 1); ex(R2+2, 0, 0); ex(R2+3, 5, 0);
    ex(R2+7, 1, 0); ex(R2+100, 1, 0); ex(R2+216, 1, 0);
    ex(R2+217, 1, 1); ex(R2+5, 3, 0); ex(R2+6, 3, 1);
    ex(R2+49, 2, 0); ex(R2+50, 2, 1);
`ifdef CD_CTRL_TICK_EN
    ex(R2+217, 10, 1);
`endif
    at(R+1360); drv(1, 1, 7);
    at(R+1361); drv(0, 1, 0);
    at(R+1363); rst_n = 1'b0;
    at(R2); rst_n = 1'b1;

    at(R2+222);
    n_cmp++;
    if (busy !== 4'b0000) begin
      n_bad++;
      $display("FAIL busy cyc=%0d actual=%b required=0000", cyc, busy);
    end
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL cfg_ready cyc=%0d actual=%b required=1",
               cyc, cfg_ready);
    end
    while (q.size() > 0) begin
      e_left();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic e_left();
    chk_t e;
    e = q.pop_front();
    n_cmp++;
    n_bad++;
    $display("FAIL %s cyc=%0d actual=unchecked required=%b",
             sname(e.sig), e.cyc, e.val);
  endtask

endmodule
